// File: rtl/k_and_s_pkg.sv
// k_and_s_pkg: shared types for the K-and-S processor.
//   decoded_instruction_type : opcode class produced by data_path
//   control_state_type       : control_unit sequencing states
//   ALU_OR/ALU_ADD/ALU_SUB/ALU_AND : ALU operation codes
//   alu_op_for()             : ALU operation selected by an ALU-class opcode
package k_and_s_pkg;

  typedef enum logic [3:0] {
    I_NOP,
    I_LOAD,
    I_STORE,
    I_MOVE,
    I_ADD,
    I_SUB,
    I_AND,
    I_OR,
    I_BRANCH,
    I_BZERO,
    I_BNZERO,
    I_BNEG,
    I_BNNEG,
    I_BOV,
    I_BNOV,
    I_HALT
  } decoded_instruction_type;

  typedef enum logic [3:0] {
    FETCH,
    LOAD_IR,
    DECODE,
    LOAD_1,
    LOAD_2,
    STORE_1,
    ALU_1,
    MOVE_1,
    BRANCH_1,
    HALTED
  } control_state_type;

  localparam logic [1:0] ALU_OR  = 2'b00;
  localparam logic [1:0] ALU_ADD = 2'b01;
  localparam logic [1:0] ALU_SUB = 2'b10;
  localparam logic [1:0] ALU_AND = 2'b11;

  function automatic logic [1:0] alu_op_for(input decoded_instruction_type instr);
    logic [1:0] op;
    case (instr)
      I_ADD:   op = ALU_ADD;
      I_SUB:   op = ALU_SUB;
      I_AND:   op = ALU_AND;
      default: op = ALU_OR;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/control_unit.sv
// control_unit: sequencing FSM of the K-and-S processor. Steps every
// instruction through FETCH, LOAD_IR, DECODE and an execute state, and
// drives the data_path strobes and the RAM write enable as Moore outputs.
//
// Parameters:
//   COUNT_WIDTH : width of the retired-instruction counter (default 16)
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   decoded_instruction : opcode class from data_path (sampled in DECODE)
//   zero_op, neg_op, unsigned_overflow : registered ALU flags
//   branch, pc_enable, ir_enable, addr_sel, c_sel, operation,
//   write_reg_enable, flags_reg_enable, ram_write_enable : data_path controls
//   halt                : high while stopped on HALT
//   instr_count         : retired-instruction count (only with the macro below)
// Configuration macro:
//   CONTROL_UNIT_INSTR_COUNT_EN : adds the instr_count port and counter.
//
// The internal signal 'state' (control_state_type) is the FSM state and is
// the intended hook for bound checkers.
module control_unit
  import k_and_s_pkg::*;
#(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  decoded_instruction_type decoded_instruction,
  input  logic                    zero_op,
  input  logic                    neg_op,
  input  logic                    unsigned_overflow,
  output logic                    branch,
  output logic                    pc_enable,
  output logic                    ir_enable,
  output logic                    addr_sel,
  output logic                    c_sel,
  output logic [1:0]              operation,
  output logic                    write_reg_enable,
  output logic                    flags_reg_enable,
  output logic                    ram_write_enable,
  output logic                    halt
`ifdef CONTROL_UNIT_INSTR_COUNT_EN
  ,
  output logic [COUNT_WIDTH-1:0]  instr_count
`endif
);

  control_state_type state;
  control_state_type next_state;

  // The ALU operation is captured in DECODE so that ALU_1 stays a pure
  // function of registered state and never looks at decoded_instruction.
  logic [1:0] alu_op_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= FETCH;
      alu_op_q <= ALU_OR;
    end else begin
      state <= next_state;
      if (state == DECODE) begin
        alu_op_q <= alu_op_for(decoded_instruction);
      end
    end
  end

  always_comb begin
    next_state       = state;
    branch           = 1'b0;
    pc_enable        = 1'b0;
    ir_enable        = 1'b0;
    addr_sel         = 1'b0;
    c_sel            = 1'b0;
    operation        = ALU_OR;
    write_reg_enable = 1'b0;
    flags_reg_enable = 1'b0;
    ram_write_enable = 1'b0;
    halt             = 1'b0;
    case (state)
      FETCH: begin
        next_state = LOAD_IR;
      end
      LOAD_IR: begin
        ir_enable  = 1'b1;
        pc_enable  = 1'b1;
        next_state = DECODE;
      end
      DECODE: begin
        case (decoded_instruction)
          I_LOAD:   next_state = LOAD_1;
          I_STORE:  next_state = STORE_1;
          I_ADD,
          I_SUB,
          I_AND,
          I_OR:     next_state = ALU_1;
          I_MOVE:   next_state = MOVE_1;
          I_HALT:   next_state = HALTED;
          I_BRANCH: next_state = BRANCH_1;
          I_BZERO:  next_state = zero_op            ? BRANCH_1 : FETCH;
          I_BNZERO: next_state = !zero_op           ? BRANCH_1 : FETCH;
          I_BNEG:   next_state = neg_op             ? BRANCH_1 : FETCH;
          I_BNNEG:  next_state = !neg_op            ? BRANCH_1 : FETCH;
          I_BOV:    next_state = unsigned_overflow  ? BRANCH_1 : FETCH;
          I_BNOV:   next_state = !unsigned_overflow ? BRANCH_1 : FETCH;
          default:  next_state = FETCH;
        endcase
      end
      LOAD_1: begin
        addr_sel   = 1'b1;
        next_state = LOAD_2;
      end
      LOAD_2: begin
        addr_sel         = 1'b1;
        write_reg_enable = 1'b1;
        next_state       = FETCH;
      end
      STORE_1: begin
        addr_sel         = 1'b1;
        ram_write_enable = 1'b1;
        next_state       = FETCH;
      end
      ALU_1: begin
        c_sel            = 1'b1;
        operation        = alu_op_q;
        write_reg_enable = 1'b1;
        flags_reg_enable = 1'b1;
        next_state       = FETCH;
      end
      MOVE_1: begin
        // A OR A copies the source register, since both ALU inputs are A.
        c_sel            = 1'b1;
        write_reg_enable = 1'b1;
        next_state       = FETCH;
      end
      BRANCH_1: begin
        pc_enable  = 1'b1;
        branch     = 1'b1;
        next_state = FETCH;
      end
      HALTED: begin
        halt       = 1'b1;
        next_state = HALTED;
      end
      default: begin
        next_state = FETCH;
      end
    endcase
  end

`ifdef CONTROL_UNIT_INSTR_COUNT_EN
  // An instruction retires when the FSM re-enters FETCH from any execute
  // state or DECODE, or enters HALTED. FETCH and LOAD_IR never lead to
  // FETCH, so "entering FETCH from elsewhere" covers exactly those states.
  logic                   retire;
  logic [COUNT_WIDTH-1:0] count_q;

  assign retire = ((next_state == FETCH)  && (state != FETCH)) ||
                  ((next_state == HALTED) && (state != HALTED));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (retire) begin
      count_q <= count_q + COUNT_WIDTH'(1);
    end
  end

  assign instr_count = count_q;
`else
  // Counter not built: FSM behaviour is unchanged.
`endif

endmodule
